// File: rtl/cam_pattern_tx.sv
// cam_pattern_tx: camera-style (OV7670-like) RGB444 test pattern source.
// Ports: clk, rst_n (async low), en, pattern_sel, solid_rgb in;
//        vsync, href, d (byte bus), busy, frame_done, frame_cnt out.
module cam_pattern_tx #(
    parameter int H_PIX       = 320,
    parameter int V_LINES     = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_rgb,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [2:0] {
        IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT
    } state_t;

    localparam logic [31:0] LINE_LEN  = 32'(2 * H_PIX + H_BLANK);
    localparam logic [31:0] ACT_LEN   = 32'(2 * H_PIX);
    localparam logic [31:0] HB_LEN    = 32'(H_BLANK);
    localparam logic [31:0] VS_LEN    = 32'(VSYNC_LINES) * LINE_LEN;
    localparam logic [31:0] VB_LEN    = 32'(VBP_LINES) * LINE_LEN;
    localparam logic [31:0] VF_LEN    = 32'(VFP_LINES) * LINE_LEN;
    localparam logic [31:0] LAST_LINE = 32'(V_LINES - 1);
    localparam logic [31:0] BAR_W     = 32'(H_PIX / 8);
    // Zero-length vertical phases are skipped outright.
    localparam state_t FIRST = (VSYNC_LINES > 0) ? VSYNC :
                               (VBP_LINES > 0) ? VBACK : LINE;
    localparam state_t AFTER_VS = (VBP_LINES > 0) ? VBACK : LINE;
    // Lines narrower than 8 pixels have zero-width bars: all bar 7.
    localparam logic [2:0] BAR_START = (BAR_W == 0) ? 3'd7 : 3'd0;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] line_q, line_d;
    logic [31:0] bpix_q, bpix_d;
    logic [2:0]  bar_q, bar_d;
    logic [11:0] idx_q, idx_d;
    logic [1:0]  pat_q, pat_d;
    logic [11:0] rgb_q, rgb_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  d_q, d_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        eof, start;
    logic [11:0] bar_rgb, pix;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        line_d  = line_q;
        bpix_d  = bpix_q;
        bar_d   = bar_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        rgb_d   = rgb_q;
        eof     = 1'b0;
        start   = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                start = en;
            end
            VSYNC: begin
                if (cnt_q == VS_LEN - 32'd1) begin
                    cnt_d   = '0;
                    state_d = AFTER_VS;
                end
            end
            VBACK: begin
                if (cnt_q == VB_LEN - 32'd1) begin
                    cnt_d   = '0;
                    state_d = LINE;
                end
            end
            LINE: begin
                if (cnt_q == ACT_LEN - 32'd1) begin
                    cnt_d   = '0;
                    state_d = HBLANK;
                end
            end
            HBLANK: begin
                if (cnt_q == HB_LEN - 32'd1) begin
                    cnt_d = '0;
                    if (line_q == LAST_LINE) begin
                        line_d = '0;
                        if (VFP_LINES > 0) state_d = VFRONT;
                        else               eof     = 1'b1;
                    end else begin
                        line_d  = line_q + 32'd1;
                        state_d = LINE;
                    end
                end
            end
            VFRONT: begin
                if (cnt_q == VF_LEN - 32'd1) eof = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (eof) begin
            cnt_d = '0;
            if (en) start = 1'b1;
            else    state_d = IDLE;
        end

        // Pixel-rate counters step after the second byte of each pixel.
        if (state_q == LINE && cnt_q[0]) begin
            idx_d = idx_q + 12'd1;
            if (bpix_q == BAR_W - 32'd1) begin
                bpix_d = '0;
                if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
            end else begin
                bpix_d = bpix_q + 32'd1;
            end
        end
        if (state_d != LINE) begin
            bar_d  = BAR_START;
            bpix_d = '0;
        end

        if (start) begin
            state_d = FIRST;
            cnt_d   = '0;
            line_d  = '0;
            idx_d   = '0;
            pat_d   = pattern_sel;
            rgb_d   = solid_rgb;
        end
    end

    // Outputs are derived from next-state values, then registered.
    always_comb begin
        bar_rgb = 12'h000;
        unique case (bar_d)
            3'd0: bar_rgb = 12'hFFF;
            3'd1: bar_rgb = 12'hFF0;
            3'd2: bar_rgb = 12'h0FF;
            3'd3: bar_rgb = 12'h0F0;
            3'd4: bar_rgb = 12'hF0F;
            3'd5: bar_rgb = 12'hF00;
            3'd6: bar_rgb = 12'h00F;
            3'd7: bar_rgb = 12'h000;
            default: bar_rgb = 12'h000;
        endcase

        if (VFP_LINES > 0)
            done_d = (state_d == VFRONT) && (cnt_d == VF_LEN - 32'd1);
        else
            done_d = (state_d == HBLANK) && (cnt_d == HB_LEN - 32'd1)
                     && (line_d == LAST_LINE);
        fcnt_d = fcnt_q + {7'd0, done_d};

        pix = 12'h000;
        unique case (pat_d)
            2'd0: pix = bar_rgb;
            2'd1: pix = {cnt_d[4:1], line_d[3:0], fcnt_d[3:0]};
            2'd2: pix = rgb_d;
            2'd3: pix = idx_d;
            default: pix = 12'h000;
        endcase

        vsync_d = (state_d == VSYNC);
        href_d  = (state_d == LINE);
        busy_d  = (state_d != IDLE);
        d_d     = 8'h00;
        if (href_d) d_d = cnt_d[0] ? pix[7:0] : {4'h0, pix[11:8]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            bpix_q  <= '0;
            bar_q   <= BAR_START;
            idx_q   <= '0;
            pat_q   <= '0;
            rgb_q   <= '0;
            fcnt_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            bpix_q  <= bpix_d;
            bar_q   <= bar_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            rgb_q   <= rgb_d;
            fcnt_q  <= fcnt_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign d          = d_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_cam_pattern_tx.sv
// tb_cam_pattern_tx: directed bench for cam_pattern_tx (small geometry).
// Instance a: H_PIX=4 (timing, index, stop, wrap, reset); b: H_PIX=8 (bars).
module tb_cam_pattern_tx;

    logic        clk = 1'b0;
    logic        rst_n, en, en_b;
    logic [1:0]  psel, psel_b;
    logic [11:0] rgb, rgb_b;
    logic        vsync, href, busy, frame_done;
    logic [7:0]  d, frame_cnt;
    logic        vsync_b, href_b, busy_b, fd_b;
    logic [7:0]  d_b, fc_b;

    logic        vs_a [1:64];
    logic        hr_a [1:64];
    logic        bs_a [1:64];
    logic        fd_a [1:64];
    logic [7:0]  d_a  [1:64];
    logic [7:0]  bb   [0:31];
    logic [7:0]  bars_exp [0:15];

    int errors = 0;
    int checks = 0;
    int nd, n, k, nbad, found;

    always #5 clk = ~clk;

    cam_pattern_tx #(
        .H_PIX(4), .V_LINES(2), .H_BLANK(3),
        .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .pattern_sel(psel), .solid_rgb(rgb),
        .vsync(vsync), .href(href), .d(d), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    cam_pattern_tx #(
        .H_PIX(8), .V_LINES(2), .H_BLANK(3),
        .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b),
        .pattern_sel(psel_b), .solid_rgb(rgb_b),
        .vsync(vsync_b), .href(href_b), .d(d_b), .busy(busy_b),
        .frame_done(fd_b), .frame_cnt(fc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input int cnt);
        for (int i = 1; i <= cnt; i++) begin
            step();
            vs_a[i] = vsync;
            hr_a[i] = href;
            bs_a[i] = busy;
            fd_a[i] = frame_done;
            d_a[i]  = d;
        end
    endtask

    function automatic logic f1_href(int c);
        return (c >= 23 && c <= 30) || (c >= 34 && c <= 41);
    endfunction

    function automatic logic [7:0] f1_d(int c);
        int off;
        if (!f1_href(c)) return 8'h00;
        off = (c <= 30) ? c - 23 : c - 34;
        return (off % 2 == 0) ? 8'h0A : 8'h5C;
    endfunction

    // Active-cycle number (23..30, 34..41) to byte index 0..15.
    function automatic int kof(int c);
        return (c <= 30) ? c - 23 : c - 26;
    endfunction

    initial begin
        bars_exp = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
                     8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};
        rst_n = 1'b0; en = 1'b0; en_b = 1'b0;
        psel = 2'd0; rgb = 12'h000; psel_b = 2'd0; rgb_b = 12'h000;
        repeat (3) step();
        chk("rst_vsync", vsync, 0);
        chk("rst_href", href, 0);
        chk("rst_d", d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        repeat (2) step();
        chk("idle_busy", busy, 0);

        // Frame 1: solid A5C, full timing.
        psel = 2'd2; rgb = 12'hA5C; en = 1'b1;
        cap(55);
        for (int c = 1; c <= 55; c++) begin
            chk("f1_vsync", vs_a[c], 32'(c <= 11));
            chk("f1_href", hr_a[c], 32'(f1_href(c)));
            chk("f1_d", d_a[c], f1_d(c));
            chk("f1_done", fd_a[c], 32'(c == 55));
            chk("f1_busy", bs_a[c], 1);
        end
        step();
        chk("f2_vsync", vsync, 1);
        chk("f1_cnt", frame_cnt, 1);

        // Mid-frame pattern change must wait for the next frame.
        psel = 2'd3;
        cap(54);
        chk("f2_byte0", d_a[22], 8'h0A);
        chk("f2_byte1", d_a[23], 8'h5C);
        chk("f2_done", fd_a[54], 1);

        // Frame 3: index pattern.
        cap(55);
        for (int c = 23; c <= 41; c++) begin
            if (f1_href(c)) begin
                k = kof(c);
                chk("idx_byte", d_a[c], (k % 2 == 0) ? 0 : k / 2);
            end
        end

        // Frame 4: drop en mid line 0.
        cap(25);
        en = 1'b0;
        cap(30);
        chk("stop_href", hr_a[9], 1);
        chk("stop_b0", d_a[9], 8'h00);
        chk("stop_b1", d_a[10], 8'h04);
        chk("stop_done", fd_a[30], 1);
        cap(20);
        nbad = 0;
        for (int c = 1; c <= 20; c++)
            if (vs_a[c] || hr_a[c] || bs_a[c] || fd_a[c]) nbad++;
        chk("stop_quiet", nbad, 0);
        chk("stop_cnt", frame_cnt, 4);

        // Back-to-back frames up to the counter wrap.
        en = 1'b1;
        for (int f = 5; f <= 256; f++) begin
            step();
            chk("wrap_vsync", vsync, 1);
            chk("wrap_cnt", frame_cnt, (f - 1) & 255);
            nd = 0;
            repeat (54) begin
                step();
                nd += int'(frame_done);
            end
            chk("wrap_pulses", nd, 1);
        end
        step();
        chk("wrap_zero", frame_cnt, 0);
        psel = 2'd1;
        repeat (54) step();
        cap(55);
        for (int c = 23; c <= 41; c++) begin
            if (f1_href(c)) begin
                k = kof(c);
                chk("grad_byte", d_a[c],
                    (k % 2 == 0) ? (k % 8) / 2 : ((k / 8) << 4) | 1);
            end
        end

        // Colour bars on the wide instance.
        en = 1'b0;
        en_b = 1'b1;
        n = 0;
        for (int t = 0; t < 200 && n < 32; t++) begin
            step();
            if (href_b) begin
                bb[n] = d_b;
                n++;
            end
        end
        en_b = 1'b0;
        chk("bars_count", n, 32);
        for (int i = 0; i < 32; i++)
            chk("bars_byte", bb[i], bars_exp[i % 16]);
        repeat (10) step();
        chk("stop2_busy", busy, 0);

        // Reset during href.
        en = 1'b1;
        found = 0;
        for (int t = 0; t < 100; t++) begin
            step();
            if (href) begin
                found = 1;
                break;
            end
        end
        chk("rst_wait", found, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_href", href, 0);
        chk("mrst_vsync", vsync, 0);
        chk("mrst_d", d, 0);
        chk("mrst_cnt", frame_cnt, 0);
        chk("mrst_busy", busy, 0);
        en = 1'b0;
        nbad = 0;
        repeat (3) begin
            step();
            if (frame_done) nbad++;
        end
        rst_n = 1'b1;
        repeat (60) begin
            step();
            if (frame_done || busy || vsync) nbad++;
        end
        chk("mrst_quiet", nbad, 0);
        chk("mrst_cnt2", frame_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
